// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types for the main-memory arbiter.
// FSM encodings, requester IDs and the fixed priority order.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } arb_state_e;

  typedef enum logic [1:0] {
    REQ_AC = 2'd0,
    REQ_PU = 2'd1,
    REQ_IO = 2'd2
  } req_id_e;

  localparam int NREQ = 3;

  // Highest priority in the low field.
  localparam logic [2*NREQ-1:0] PRIO_ORDER = {REQ_IO, REQ_PU, REQ_AC};

  function automatic req_id_e pick_req(input logic [NREQ-1:0] i_pend);
    req_id_e w_id;
    w_id = REQ_AC;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (i_pend[PRIO_ORDER[2*i +: 2]]) begin
        w_id = req_id_e'(PRIO_ORDER[2*i +: 2]);
      end
    end
    return w_id;
  endfunction

endpackage

// File: rtl/mem_req_slot.sv
// mem_req_slot: one requester's pending bit and latched operands.
// Flags a request that lands on an already pending slot.
module mem_req_slot
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 31
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              i_req,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_rel,
  input  logic              i_clear,
  output logic              o_pending,
  output logic              o_we,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_wdata,
  output logic              o_ovr
);

  logic              r_pending;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              w_take;

  // A slot being released this cycle can accept a fresh request.
  assign w_take = i_req & (~r_pending | i_rel);
  assign o_ovr  = i_req & r_pending & ~i_rel & ~i_clear;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pending <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
    end else if (i_clear) begin
      r_pending <= 1'b0;
    end else if (w_take) begin
      r_pending <= 1'b1;
      r_we      <= i_we;
      r_addr    <= i_addr;
      r_wdata   <= i_wdata;
    end else if (i_rel) begin
      r_pending <= 1'b0;
    end
  end

  assign o_pending = r_pending;
  assign o_we      = r_we;
  assign o_addr    = r_addr;
  assign o_wdata   = r_wdata;

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: fixed-priority sharing of the main-memory port.
// Watchdog is built only with `define MEM_ARB_TIMEOUT_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 31,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              pu_rd_from_pu,
  input  logic [ADDR_W-1:0] pu_addr_from_sel,
  output logic              pu_reply_to_pu,
  input  logic              ac_wr_from_ac,
  input  logic [ADDR_W-1:0] ac_addr_from_sel,
  input  logic [DATA_W-1:0] ac_wdata_from_ac,
  output logic              ac_reply_to_ac,
  input  logic              io_req_from_io,
  input  logic              io_we_from_io,
  input  logic [ADDR_W-1:0] io_addr_from_io,
  input  logic [DATA_W-1:0] io_wdata_from_io,
  output logic              io_reply_to_io,
  output logic [DATA_W-1:0] rdata_to_all,
  output logic              mem_req_to_mem,
  output logic              mem_we_to_mem,
  output logic [ADDR_W-1:0] mem_addr_to_mem,
  output logic [DATA_W-1:0] mem_wdata_to_mem,
  input  logic              mem_ack_from_mem,
  input  logic [DATA_W-1:0] mem_rdata_from_mem,
  input  logic              clear_from_pnl,
  output logic              overrun_to_pnl,
  output logic              timeout_to_pnl,
  output logic [1:0]        arb_state_to_pnl
);

  if (TIMEOUT_CYC < 1) begin : g_bad_tmo
    $error("TIMEOUT_CYC must be at least 1");
  end

  logic [NREQ-1:0]   w_req;
  logic [NREQ-1:0]   w_we_in;
  logic [ADDR_W-1:0] w_addr_in  [NREQ];
  logic [DATA_W-1:0] w_wdata_in [NREQ];
  logic [NREQ-1:0]   w_pend;
  logic [NREQ-1:0]   w_s_we;
  logic [ADDR_W-1:0] w_s_addr   [NREQ];
  logic [DATA_W-1:0] w_s_wdata  [NREQ];
  logic [NREQ-1:0]   w_ovr;

  arb_state_e        r_state;
  arb_state_e        w_state_nxt;
  req_id_e           r_gnt;
  req_id_e           w_sel;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [NREQ-1:0]   r_reply;
  logic [DATA_W-1:0] r_rdata;
  logic              r_overrun;
  logic              r_timeout;
  logic              w_grant;
  logic              w_done;
  logic              w_tmo;
  logic              w_tmo_hit;

  assign w_req   = {io_req_from_io, pu_rd_from_pu, ac_wr_from_ac};
  assign w_we_in = {io_we_from_io, 1'b0, 1'b1};

  assign w_addr_in[REQ_AC]  = ac_addr_from_sel;
  assign w_addr_in[REQ_PU]  = pu_addr_from_sel;
  assign w_addr_in[REQ_IO]  = io_addr_from_io;
  assign w_wdata_in[REQ_AC] = ac_wdata_from_ac;
  assign w_wdata_in[REQ_PU] = '0;
  assign w_wdata_in[REQ_IO] = io_wdata_from_io;

  for (genvar g = 0; g < NREQ; g++) begin : g_slot
    mem_req_slot #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
    ) u_slot (
      .clk       (clk),
      .resetn    (resetn),
      .i_req     (w_req[g]),
      .i_we      (w_we_in[g]),
      .i_addr    (w_addr_in[g]),
      .i_wdata   (w_wdata_in[g]),
      .i_rel     (r_reply[g]),
      .i_clear   (clear_from_pnl),
      .o_pending (w_pend[g]),
      .o_we      (w_s_we[g]),
      .o_addr    (w_s_addr[g]),
      .o_wdata   (w_s_wdata[g]),
      .o_ovr     (w_ovr[g])
    );
  end

  assign w_sel = pick_req(w_pend);

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TMO_W-1:0] r_tmo_cnt;
  logic             w_cnt_run;

  assign w_cnt_run = ((r_state == ST_WAIT) || (r_state == ST_DRAIN))
                   && (w_state_nxt == r_state);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_tmo_cnt <= '0;
    end else if (w_cnt_run) begin
      r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
    end else begin
      r_tmo_cnt <= '0;
    end
  end

  assign w_tmo_hit = (r_tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
`else
  assign w_tmo_hit = 1'b0;
`endif

  // A reply pulse still in flight holds off the next grant for a cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_done      = 1'b0;
    w_tmo       = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (!clear_from_pnl && (|w_pend) && !(|r_reply)) begin
          w_grant     = 1'b1;
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_state_nxt = clear_from_pnl ? ST_DRAIN : ST_WAIT;
      end
      ST_WAIT: begin
        if (mem_ack_from_mem) begin
          w_state_nxt = ST_IDLE;
          w_done      = ~clear_from_pnl;
        end else if (clear_from_pnl) begin
          w_state_nxt = ST_DRAIN;
        end else if (w_tmo_hit) begin
          w_state_nxt = ST_IDLE;
          w_done      = 1'b1;
          w_tmo       = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (mem_ack_from_mem) begin
          w_state_nxt = ST_IDLE;
        end else if (w_tmo_hit) begin
          w_state_nxt = ST_IDLE;
          w_tmo       = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= ST_IDLE;
      r_gnt       <= REQ_AC;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_reply     <= '0;
      r_rdata     <= '0;
      r_overrun   <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_mem_req <= w_grant;
      if (w_grant) begin
        r_gnt       <= w_sel;
        r_mem_we    <= w_s_we[w_sel];
        r_mem_addr  <= w_s_addr[w_sel];
        r_mem_wdata <= w_s_wdata[w_sel];
      end
      r_reply <= '0;
      if (w_done) begin
        r_reply[r_gnt] <= 1'b1;
      end
      if (w_done && !w_tmo && !r_mem_we) begin
        r_rdata <= mem_rdata_from_mem;
      end
      if (clear_from_pnl) begin
        r_overrun <= 1'b0;
      end else if (|w_ovr) begin
        r_overrun <= 1'b1;
      end
      if (w_tmo) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign ac_reply_to_ac   = r_reply[REQ_AC];
  assign pu_reply_to_pu   = r_reply[REQ_PU];
  assign io_reply_to_io   = r_reply[REQ_IO];
  assign rdata_to_all     = r_rdata;
  assign mem_req_to_mem   = r_mem_req;
  assign mem_we_to_mem    = r_mem_we;
  assign mem_addr_to_mem  = r_mem_addr;
  assign mem_wdata_to_mem = r_mem_wdata;
  assign overrun_to_pnl   = r_overrun;
  assign timeout_to_pnl   = r_timeout;
  assign arb_state_to_pnl = r_state;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single main-memory port among three requesters: the pulse distributor's instruction/operand reads, arithmetic-control result writes, and io_unit transfers. Single-cycle request pulses are captured into per-requester pending slots, one slot is granted at a time by fixed priority, and one memory transaction is issued per grant. The memory acknowledge is routed back as a reply pulse to the granted requester only. Sits between pulse_unit / arith_ctrl / io_unit and mem.

## Interface
Parameters:
- ADDR_W, 10, memory address width
- DATA_W, 31, memory word width
- TIMEOUT_CYC, 255, watchdog limit in cycles; used only with MEM_ARB_TIMEOUT_EN

Ports:
- clk  in  1  system clock; all state changes on its rising edge
- resetn  in  1  asynchronous, active-low reset
- pu_rd_from_pu  in  1  pulse; read request from pulse_unit
- pu_addr_from_sel  in  ADDR_W  read address; sampled in the pulse cycle
- pu_reply_to_pu  out  1  pulse; the pulse_unit read has completed
- ac_wr_from_ac  in  1  pulse; write request from arith_ctrl
- ac_addr_from_sel  in  ADDR_W  write address; sampled in the pulse cycle
- ac_wdata_from_ac  in  DATA_W  write data; sampled in the pulse cycle
- ac_reply_to_ac  out  1  pulse; the arith_ctrl write has completed
- io_req_from_io  in  1  pulse; io_unit request
- io_we_from_io  in  1  1 = write, 0 = read; sampled with io_req_from_io
- io_addr_from_io  in  ADDR_W  io_unit address; sampled with io_req_from_io
- io_wdata_from_io  in  DATA_W  io_unit write data; sampled with io_req_from_io
- io_reply_to_io  out  1  pulse; the io_unit transfer has completed
- rdata_to_all  out  DATA_W  read data; held from a read reply until the next read reply
- mem_req_to_mem  out  1  pulse; start a memory transaction
- mem_we_to_mem  out  1  1 = write, 0 = read; valid while mem_req_to_mem = 1
- mem_addr_to_mem  out  ADDR_W  address; valid while mem_req_to_mem = 1
- mem_wdata_to_mem  out  DATA_W  write data; valid while mem_req_to_mem = 1
- mem_ack_from_mem  in  1  pulse; the issued transaction has completed
- mem_rdata_from_mem  in  DATA_W  read data; valid in the mem_ack_from_mem cycle
- clear_from_pnl  in  1  pulse; abandon all pending and outstanding requests
- overrun_to_pnl  out  1  level, sticky; a request arrived while its own slot was already pending
- timeout_to_pnl  out  1  level, sticky; watchdog fired (MEM_ARB_TIMEOUT_EN only, otherwise tied 0)
- arb_state_to_pnl  out  2  current FSM state, for panel display

## Operation
- **Slots:** each requester has a pending bit plus latched address, data and we.
  - A request pulse sets pending and latches the operands.
  - A request pulse arriving while its slot is already pending is dropped: the latched operands are kept and overrun_to_pnl is set.
  - Each slot clears in the cycle its reply is issued.
- **Priority (fixed):** ac write > pu read > io. Starvation of io is acceptable because pu requests are serialised by their own reply.
- **FSM:** IDLE=0, ISSUE=1, WAIT=2, DRAIN=3.
  - IDLE: if any slot is pending, register the grant and the slot's operands into the memory outputs; go to ISSUE.
  - ISSUE: assert mem_req_to_mem for exactly one cycle; go to WAIT.
  - WAIT: on mem_ack_from_mem, pulse the granted requester's reply in the next cycle; for a read, register rdata_to_all; clear the slot; go to IDLE.
  - DRAIN: wait for mem_ack_from_mem, produce no reply and no data update; go to IDLE.
- **clear_from_pnl:** clears all pending bits and overrun_to_pnl. Then:
  - in ISSUE or WAIT, go to DRAIN;
  - in IDLE, stay in IDLE;
  - in DRAIN, stay in DRAIN.
- **Simultaneous events:**
  - A request pulse arriving in the same cycle its slot's reply is issued sets pending again; the new operands are latched and no overrun is flagged.
  - clear_from_pnl in the same cycle as mem_ack_from_mem: the reply is suppressed and the FSM goes to IDLE.
  - clear_from_pnl in the same cycle as a request pulse: clear wins and the request is discarded.
- Requests to the granted slot are never merged into the transaction already in flight.

## Timing
- Reset values (asynchronous, resetn low):
  - state IDLE, all pending bits 0;
  - all reply outputs, mem_req_to_mem and mem_we_to_mem 0;
  - mem_addr_to_mem, mem_wdata_to_mem and rdata_to_all 0;
  - overrun_to_pnl and timeout_to_pnl 0.
- Reset asserted mid-transaction: any later stray mem_ack_from_mem seen in IDLE is ignored.
- Latency with no contention:
  - request pulse at cycle N;
  - pending at N+1;
  - mem_req_to_mem at N+2;
  - mem_ack_from_mem at M ≥ N+3;
  - reply pulse and rdata_to_all valid at M+1.
- The earliest next mem_req_to_mem is M+3.
- All outputs are registered.
- At most one memory transaction is outstanding at any time.

## Configuration
- Macro MEM_ARB_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT and DRAIN.
  - On reaching TIMEOUT_CYC without an ack, the FSM goes to IDLE.
  - For a slot in WAIT, that slot clears and its reply pulses anyway, with rdata_to_all unchanged.
  - timeout_to_pnl sets and is cleared only by reset.
- Undefined: no counter exists; WAIT and DRAIN wait indefinitely; timeout_to_pnl is constant 0.

## Structure
- Package mem_arb_pkg: FSM state encodings, requester IDs (AC=0, PU=1, IO=2), priority order.
- Sub-module mem_req_slot holds one requester's pending bit and latched operands, including overrun detection. It is instantiated three times.
- Arbitration, FSM, reply routing and the watchdog live in mem_arbiter itself.

## Test plan
- Single pu read of address 0x012, with ack 3 cycles after mem_req_to_mem and rdata 0x1234567 → mem_req_to_mem at N+2 with we=0, pu_reply_to_pu at ack+1, rdata_to_all = 0x1234567.
- ac write and pu read pulsed in the same cycle → ac write (we=1) issued first, pu read issued 2 cycles after the ac reply; exactly one reply each.
- Second io_req_from_io while the io slot is pending, with a different address → the first address is used and overrun_to_pnl = 1 until clear.
- clear_from_pnl during WAIT, with ack 5 cycles later → no reply and rdata_to_all unchanged; a new pu request is issued only after that ack.
- With MEM_ARB_TIMEOUT_EN and TIMEOUT_CYC = 8, and no ack → return to IDLE after 8 WAIT cycles, the requester's reply pulses, timeout_to_pnl = 1.
- resetn asserted in WAIT, then an ack after release → all outputs at reset values and the stray ack ignored.
